beta_tlb_walker: RTL and testbench
==================================

Name: beta_tlb_walker

Overview:
- Parametrised, fully associative TLB with a hardware page-table walker for the Beta MMU.
- Translates {context, virtual page} to a physical page. A hit answers in one cycle.
- On a miss, fetches a single-level PTE over the memory port, fills an entry and responds. A non-resident PTE returns a fault.
- Sits between the CPU ports and the physical cache/memory path.

Parameters:
ENTRIES, 32, number of TLB entries (power of two, ≥2)
CTX_W, 16, context-number width
ADDR_W, 32, virtual/physical address width
PAGE_BITS, 12, page-offset width; VPN/PPN = ADDR_W-PAGE_BITS bits

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
contextNum  in  CTX_W  current context, sampled at accept
pTblePtr  in  ADDR_W  page-table base, sampled at accept
req_valid  in  1  translation request
req_vaddr  in  ADDR_W  virtual address
req_ready  out  1  block can accept a request
resp_valid  out  1  one-cycle response strobe
resp_paddr  out  ADDR_W  physical address
resp_fault  out  1  PTE not resident
flush_all  in  1  invalidate every entry
flush_ctx  in  1  invalidate entries whose context equals contextNum
mem_addr  out  ADDR_W  PTE fetch address
mem_rd_en  out  1  PTE read request
mem_data_in  in  32  PTE data
mem_ready  in  1  PTE data valid

Behaviour:
- Reset: state IDLE; all valid bits cleared; victim pointer 0; drop flag 0. Outputs: req_ready=1, resp_valid=0, resp_paddr=0, resp_fault=0, mem_rd_en=0, mem_addr=0.
- Tag per entry: {ctx, VPN} plus a valid bit. Data per entry: PPN. Lookup is combinational over all entries; on multiple matches the lowest index wins.
- State IDLE (req_ready=1):
  - On req_valid, latch vaddr, ctx and ptbr.
  - On a hit, register paddr={PPN, offset} and fault=0, then go to RESP. Accept cycle N gives resp_valid at N+1.
  - On a miss, go to WALK.
- State WALK (req_ready=0):
  - mem_rd_en=1 and mem_addr=ptbr+{VPN,2'b00}, truncated to ADDR_W (wraps), both held stable until mem_ready.
  - When mem_ready arrives:
    - PTE[0]=1: fill {ctx,VPN,PTE[31:PAGE_BITS]}; paddr={PTE PPN, offset}; fault=0.
    - PTE[0]=0: no fill; fault=1; paddr=0.
  - Then go to RESP. mem_rd_en drops in the cycle after mem_ready.
- State RESP: resp_valid=1 for exactly one cycle. resp_paddr and resp_fault hold until the next response. Next state IDLE.
- Victim selection: the lowest-index invalid entry if one exists. Otherwise the round-robin pointer, which then increments modulo ENTRIES. The pointer advances only on a fill that uses it.
- Flush:
  - Takes effect in one cycle in any state; flush_all has priority over flush_ctx.
  - A flush asserted during WALK sets the drop flag; the completing walk still responds but skips the fill.
  - A flush in the same cycle as a fill suppresses that fill.
  - A flush in the same cycle as an IDLE accept uses the pre-flush lookup for that request.
- No duplicate entries: fills occur only after a miss, and the lookup key is latched.
- Reset mid-WALK: the walk is abandoned, mem_rd_en=0 next cycle, and no response is issued.
- contextNum and pTblePtr changes after accept do not affect the in-flight request.

Decomposition:
- Package beta_mmu_pkg holds:
  - state enum {IDLE, WALK, RESP};
  - PTE field constants (PTE_VALID_BIT=0, PPN at [31:PAGE_BITS]);
  - a function computing the PTE address.
- Sub-module beta_tlb_cam holds:
  - the tag/data/valid arrays with combinational lookup (hit, index, PPN);
  - the write port and first-invalid detection;
  - the flush_all/flush_ctx clears.
- The walker FSM stays in beta_tlb_walker.

Test Plan:
- Cold miss, resident: ctx=3, ptbr=0x1000, vaddr=0x00005ABC, PTE=0x0007_7001 → mem_addr=0x1014; resp_paddr=0x00077ABC, fault=0. Same request again → resp_valid 1 cycle after accept, with no mem_rd_en.
- Non-resident: PTE=0x0007_7000 → resp_fault=1, no fill. Repeat of the same request → walks again.
- Context isolation: fill VPN 5 under ctx 3, then request VPN 5 under ctx 4 → miss and walk. flush_ctx with contextNum=3 → ctx 3 misses, ctx 4 entry still hits.
- Replacement: fill ENTRIES+2 distinct VPNs → entries 0..ENTRIES-1 are filled in order, then the pointer evicts 0 and then 1. VPNs 0 and 1 miss; VPN 2 hits.
- Flush during walk: assert flush_all while mem_ready is held low for 5 cycles → the response is correct but not cached, and the next identical request walks again.
- Wrap: ptbr=0xFFFFFFF0, VPN=8 → mem_addr=0x00000010. rst asserted mid-WALK → req_ready=1 and mem_rd_en=0 the next cycle, and no resp_valid.

Source files
------------

// File: rtl/beta_mmu_pkg.sv
// Purpose: shared walker state encoding, PTE field layout and PTE address helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package beta_mmu_pkg;

  // Walker FSM states (IDLE / WALK / RESP)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // PTE layout: bit 0 is the resident flag, PPN lives in [31:PAGE_BITS]
  localparam int PTE_VALID_BIT = 0;
  localparam int PTE_W         = 32;

  // PTE address = table base + VPN*4; callers truncate to their address width,
  // so the sum deliberately wraps at ADDR_W.
  function automatic logic [63:0] pte_addr(input logic [63:0] ptbr,
                                           input logic [63:0] vpn);
    return ptbr + (vpn << 2);
  endfunction

endpackage

// File: rtl/beta_tlb_cam.sv
// Purpose: fully associative tag/data store with lookup, fill port and flushes.
// Latency: lookup and free-slot search are combinational; writes/flushes land next edge.
// Backpressure: none; a flush in the same cycle as a write wins over the write.
module beta_tlb_cam
  import beta_mmu_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int CTX_W   = 16,
  parameter int VPN_W   = 20,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CTX_W-1:0] i_lk_ctx,
  input  logic [VPN_W-1:0] i_lk_vpn,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_hit_idx,
  output logic [VPN_W-1:0] o_hit_ppn,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [CTX_W-1:0] i_wr_ctx,
  input  logic [VPN_W-1:0] i_wr_vpn,
  input  logic [VPN_W-1:0] i_wr_ppn,
  output logic             o_has_free,
  output logic [IDX_W-1:0] o_free_idx,
  input  logic             i_flush_all,
  input  logic             i_flush_ctx,
  input  logic [CTX_W-1:0] i_flush_ctx_val
);

  logic [ENTRIES-1:0] r_valid;
  logic [CTX_W-1:0]   r_tag_ctx [ENTRIES];
  logic [VPN_W-1:0]   r_tag_vpn [ENTRIES];
  logic [VPN_W-1:0]   r_ppn     [ENTRIES];

  logic w_wr_ok;
  assign w_wr_ok = i_wr_en & ~i_flush_all & ~i_flush_ctx;

  // Parallel tag match; scanning downward lets the lowest matching index win
  always_comb begin
    o_hit     = 1'b0;
    o_hit_idx = '0;
    o_hit_ppn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_tag_ctx[i] == i_lk_ctx && r_tag_vpn[i] == i_lk_vpn) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
        o_hit_ppn = r_ppn[i];
      end
    end
  end

  // Lowest-index invalid slot, preferred over the round-robin victim
  always_comb begin
    o_has_free = 1'b0;
    o_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        o_has_free = 1'b1;
        o_free_idx = IDX_W'(i);
      end
    end
  end

  // Valid bits: reset/flush clear, fills set; flush_all beats flush_ctx beats fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush_all) begin
      r_valid <= '0;
    end else if (i_flush_ctx) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_tag_ctx[i] == i_flush_ctx_val) r_valid[i] <= 1'b0;
      end
    end else if (w_wr_ok) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and PPN payload; only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_tag_ctx[i_wr_idx] <= i_wr_ctx;
      r_tag_vpn[i_wr_idx] <= i_wr_vpn;
      r_ppn[i_wr_idx]     <= i_wr_ppn;
    end
  end

endmodule

// File: rtl/beta_tlb_walker.sv
// Purpose: TLB front end with single-level hardware page-table walker.
// Latency: hit responds 1 cycle after accept; miss responds 1 cycle after mem_ready.
// Backpressure: req_ready low while walking or responding; PTE fetch held until mem_ready.
module beta_tlb_walker
  import beta_mmu_pkg::*;
#(
  parameter int ENTRIES   = 32,
  parameter int CTX_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int PAGE_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTX_W-1:0]  contextNum,
  input  logic [ADDR_W-1:0] pTblePtr,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_vaddr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_paddr,
  output logic              resp_fault,
  input  logic              flush_all,
  input  logic              flush_ctx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ready
);

  localparam int VPN_W = ADDR_W - PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_vaddr;
  logic [ADDR_W-1:0] r_ptbr;
  logic [CTX_W-1:0]  r_ctx;
  logic              r_drop;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [ADDR_W-1:0] r_resp_paddr;
  logic              r_resp_fault;

  logic              w_idle;
  logic              w_walk;
  logic              w_flush;
  logic              w_pte_valid;
  logic              w_fill;
  logic              w_hit;
  logic [IDX_W-1:0]  w_unused_hit_idx;
  logic [VPN_W-1:0]  w_hit_ppn;
  logic              w_has_free;
  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_victim;
  logic [VPN_W-1:0]  w_pte_ppn;
  logic              w_unused_pte;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_walk      = (r_state == ST_WALK);
  assign w_flush     = flush_all | flush_ctx;
  assign w_pte_valid = mem_data_in[PTE_VALID_BIT];
  assign w_pte_ppn   = VPN_W'(mem_data_in[PTE_W-1:PAGE_BITS]);
  assign w_unused_pte = ^mem_data_in[PAGE_BITS-1:1];
  // A walk that saw any flush (now or earlier) must not repopulate the TLB
  assign w_fill      = w_walk & mem_ready & w_pte_valid & ~r_drop & ~w_flush;
  assign w_victim    = w_has_free ? w_free_idx : r_rr_ptr;

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_paddr = r_resp_paddr;
  assign resp_fault = r_resp_fault;
  assign mem_rd_en  = w_walk;
  assign mem_addr   = w_walk ? ADDR_W'(pte_addr(64'(r_ptbr), 64'(r_vaddr[ADDR_W-1:PAGE_BITS])))
                             : '0;

  // Lookup key is the live request: the accept cycle sees the pre-flush contents
  beta_tlb_cam #(
    .ENTRIES (ENTRIES),
    .CTX_W   (CTX_W),
    .VPN_W   (VPN_W),
    .IDX_W   (IDX_W)
  ) u_cam (
    .clk             (clk),
    .rst             (rst),
    .i_lk_ctx        (contextNum),
    .i_lk_vpn        (req_vaddr[ADDR_W-1:PAGE_BITS]),
    .o_hit           (w_hit),
    .o_hit_idx       (w_unused_hit_idx),
    .o_hit_ppn       (w_hit_ppn),
    .i_wr_en         (w_fill),
    .i_wr_idx        (w_victim),
    .i_wr_ctx        (r_ctx),
    .i_wr_vpn        (r_vaddr[ADDR_W-1:PAGE_BITS]),
    .i_wr_ppn        (w_pte_ppn),
    .o_has_free      (w_has_free),
    .o_free_idx      (w_free_idx),
    .i_flush_all     (flush_all),
    .i_flush_ctx     (flush_ctx),
    .i_flush_ctx_val (contextNum)
  );

  // Walker FSM: accept/lookup, PTE fetch, single-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vaddr      <= '0;
      r_ptbr       <= '0;
      r_ctx        <= '0;
      r_drop       <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_vaddr <= req_vaddr;
            r_ptbr  <= pTblePtr;
            r_ctx   <= contextNum;
            r_drop  <= 1'b0;
            if (w_hit) begin
              r_resp_paddr <= {w_hit_ppn, req_vaddr[PAGE_BITS-1:0]};
              r_resp_fault <= 1'b0;
              r_state      <= ST_RESP;
            end else begin
              r_state <= ST_WALK;
            end
          end
        end
        ST_WALK: begin
          if (w_flush) r_drop <= 1'b1;
          if (mem_ready) begin
            if (w_pte_valid) begin
              r_resp_paddr <= {w_pte_ppn, r_vaddr[PAGE_BITS-1:0]};
              r_resp_fault <= 1'b0;
            end else begin
              r_resp_paddr <= '0;
              r_resp_fault <= 1'b1;
            end
            r_drop  <= 1'b0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Round-robin victim pointer moves only when it actually chose the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_fill && !w_has_free) begin
      r_rr_ptr <= r_rr_ptr + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_beta_tlb_walker.sv
// Purpose: directed self-checking bench for beta_tlb_walker.
// Latency: checks hit = accept+1 and miss = mem_ready+1 response timing.
// Backpressure: bench acts as PTE memory, holding mem_ready low for chosen cycles.
module tb_beta_tlb_walker;

  localparam int N_ENT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] contextNum;
  logic [31:0] pTblePtr;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        flush_all;
  logic        flush_ctx;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_data_in;
  logic        mem_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  beta_tlb_walker #(
    .ENTRIES   (N_ENT),
    .CTX_W     (16),
    .ADDR_W    (32),
    .PAGE_BITS (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .contextNum  (contextNum),
    .pTblePtr    (pTblePtr),
    .req_valid   (req_valid),
    .req_vaddr   (req_vaddr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_paddr  (resp_paddr),
    .resp_fault  (resp_fault),
    .flush_all   (flush_all),
    .flush_ctx   (flush_ctx),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready)
  );

  // One translation: drive it, act as PTE memory if it walks, check the response.
  task automatic do_req(input string nm, input logic [15:0] ctx, input logic [31:0] ptbr,
                        input logic [31:0] va, input bit exp_walk, input logic [31:0] exp_maddr,
                        input logic [31:0] pte, input int delay, input bit flush_mid,
                        input logic [31:0] exp_pa, input bit exp_fault);
    bit walked;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready: got %b want 1", nm, req_ready);
    end
    contextNum = ctx; pTblePtr = ptbr; req_vaddr = va; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    contextNum = ~ctx;
    pTblePtr = 32'hDEAD_0000;
    @(negedge clk);
    walked = (mem_rd_en === 1'b1);
    n_cmp++;
    if (walked !== exp_walk) begin
      n_fail++; $display("FAIL %s walk: got %b want %b", nm, walked, exp_walk);
    end
    if (walked) begin
      n_cmp++;
      if (mem_addr !== exp_maddr) begin
        n_fail++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, exp_maddr);
      end
      for (int c = 0; c < delay; c++) begin
        if (flush_mid && c == 1) flush_all = 1'b1;
        @(negedge clk);
        flush_all = 1'b0;
        n_cmp++;
        if (mem_rd_en !== 1'b1 || mem_addr !== exp_maddr || resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s hold: rd_en=%b addr=%h resp_valid=%b want 1/%h/0",
                   nm, mem_rd_en, mem_addr, resp_valid, exp_maddr);
        end
      end
      mem_data_in = pte; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; mem_data_in = 32'h0;
    end
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_paddr !== exp_pa || resp_fault !== exp_fault
        || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s resp: valid=%b paddr=%h fault=%b rd_en=%b want 1/%h/%b/0",
               nm, resp_valid, resp_paddr, resp_fault, mem_rd_en, exp_pa, exp_fault);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_paddr !== exp_pa || resp_fault !== exp_fault) begin
      n_fail++;
      $display("FAIL %s after: valid=%b paddr=%h fault=%b want 0/%h/%b",
               nm, resp_valid, resp_paddr, resp_fault, exp_pa, exp_fault);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_paddr !== 32'h0 ||
        resp_fault !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b rv=%b pa=%h flt=%b rd=%b ma=%h want 1/0/0/0/0/0",
               req_ready, resp_valid, resp_paddr, resp_fault, mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_cold_miss();
    do_req("cold_miss", 16'd3, 32'h1000, 32'h0000_5ABC, 1'b1, 32'h1014, 32'h0007_7001,
           2, 1'b0, 32'h0007_7ABC, 1'b0);
    do_req("cold_rehit", 16'd3, 32'h1000, 32'h0000_5ABC, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0007_7ABC, 1'b0);
  endtask

  task automatic test_nonresident();
    do_req("nonres", 16'd3, 32'h1000, 32'h0000_6123, 1'b1, 32'h1018, 32'h0007_7000,
           1, 1'b0, 32'h0, 1'b1);
    do_req("nonres_again", 16'd3, 32'h1000, 32'h0000_6123, 1'b1, 32'h1018, 32'h0007_7000,
           0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_ctx_isolation();
    do_req("ctx4_miss", 16'd4, 32'h1000, 32'h0000_5ABC, 1'b1, 32'h1014, 32'h0009_9001,
           0, 1'b0, 32'h0009_9ABC, 1'b0);
    @(negedge clk);
    contextNum = 16'd3; flush_ctx = 1'b1;
    @(negedge clk);
    flush_ctx = 1'b0;
    do_req("ctx3_flushed", 16'd3, 32'h1000, 32'h0000_5ABC, 1'b1, 32'h1014, 32'h0007_7001,
           0, 1'b0, 32'h0007_7ABC, 1'b0);
    do_req("ctx4_kept", 16'd4, 32'h1000, 32'h0000_5ABC, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0009_9ABC, 1'b0);
  endtask

  task automatic test_replacement();
    logic [31:0] v32;
    @(negedge clk);
    flush_all = 1'b1;
    @(negedge clk);
    flush_all = 1'b0;
    for (int v = 0; v < N_ENT + 2; v++) begin
      v32 = 32'(v);
      do_req("repl_fill", 16'd1, 32'h2000, (v32 << 12) | 32'h0AB, 1'b1, 32'h2000 + (v32 << 2),
             ((32'h100 + v32) << 12) | 32'h1, 0, 1'b0, ((32'h100 + v32) << 12) | 32'h0AB, 1'b0);
    end
    do_req("repl_vpn2_hit", 16'd1, 32'h2000, 32'h0000_20AB, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0010_20AB, 1'b0);
    do_req("repl_vpn9_hit", 16'd1, 32'h2000, 32'h0000_90AB, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0010_90AB, 1'b0);
    do_req("repl_vpn0_miss", 16'd1, 32'h2000, 32'h0000_00AB, 1'b1, 32'h2000, 32'h0010_0001,
           0, 1'b0, 32'h0010_00AB, 1'b0);
    do_req("repl_vpn1_miss", 16'd1, 32'h2000, 32'h0000_10AB, 1'b1, 32'h2004, 32'h0010_1001,
           0, 1'b0, 32'h0010_10AB, 1'b0);
    do_req("repl_vpn4_hit", 16'd1, 32'h2000, 32'h0000_40AB, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0010_40AB, 1'b0);
  endtask

  task automatic test_flush_in_walk();
    do_req("flush_walk", 16'd2, 32'h3000, 32'h0000_7010, 1'b1, 32'h301C, 32'h0005_5001,
           5, 1'b1, 32'h0005_5010, 1'b0);
    do_req("flush_rewalk", 16'd2, 32'h3000, 32'h0000_7010, 1'b1, 32'h301C, 32'h0005_5001,
           0, 1'b0, 32'h0005_5010, 1'b0);
    do_req("flush_then_hit", 16'd2, 32'h3000, 32'h0000_7010, 1'b0, 32'h0, 32'h0,
           0, 1'b0, 32'h0005_5010, 1'b0);
  endtask

  task automatic test_wrap_reset();
    @(negedge clk);
    contextNum = 16'd1; pTblePtr = 32'hFFFF_FFF0; req_vaddr = 32'h0000_8000; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL wrap_addr: rd_en=%b addr=%h want 1/00000010", mem_rd_en, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_walk: rdy=%b rd_en=%b rv=%b want 1/0/0", req_ready, mem_rd_en, resp_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_resp: resp_valid=%b want 0 (cycle %0d)", resp_valid, c);
      end
    end
    do_req("post_rst_miss", 16'd2, 32'h3000, 32'h0000_7010, 1'b1, 32'h301C, 32'h0005_5001,
           0, 1'b0, 32'h0005_5010, 1'b0);
  endtask

  initial begin
    rst = 1'b1; contextNum = '0; pTblePtr = '0; req_valid = 1'b0; req_vaddr = '0;
    flush_all = 1'b0; flush_ctx = 1'b0; mem_data_in = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_cold_miss();
    test_nonresident();
    test_ctx_isolation();
    test_replacement();
    test_flush_in_walk();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
